// File: rtl/bcd_time_keeper_pkg.sv
// Shared constants and helpers for the BCD time keeper: field moduli,
// digit widths and decimal-to-BCD conversion for reset preload values.
package bcd_time_keeper_pkg;

  localparam int unsigned SEC_MOD     = 60;
  localparam int unsigned MIN_MOD     = 60;
  localparam int unsigned HOUR_MOD    = 24;

  localparam int unsigned UNITS_W     = 4;
  localparam int unsigned SEC_TENS_W  = 3;
  localparam int unsigned MIN_TENS_W  = 3;
  localparam int unsigned HOUR_TENS_W = 2;

  // Two-digit packed BCD {tens, units} from a decimal value below 100.
  function automatic logic [7:0] to_bcd(input int unsigned value);
    return {4'(value / 10), 4'(value % 10)};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MODULO-1 -> 00; carry flags the wrap
// combinationally so the parent can chain fields within a single cycle.
module bcd_mod_counter
  import bcd_time_keeper_pkg::*;
#(
  parameter int unsigned MODULO = 60,
  parameter int unsigned TENS_W = 3,
  parameter logic [7:0]  INIT   = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              clear,
  output logic [TENS_W-1:0] tens,
  output logic [UNITS_W-1:0] units,
  output logic              carry
);

  localparam logic [TENS_W-1:0]  MAX_TENS   = TENS_W'((MODULO - 1) / 10);
  localparam logic [UNITS_W-1:0] MAX_UNITS  = UNITS_W'((MODULO - 1) % 10);
  localparam logic [TENS_W-1:0]  INIT_TENS  = TENS_W'(INIT[7:4]);
  localparam logic [UNITS_W-1:0] INIT_UNITS = INIT[3:0];

  logic [TENS_W-1:0]  tens_q, tens_d;
  logic [UNITS_W-1:0] units_q, units_d;
  logic               at_max;

  // Clear has priority; units roll into tens, tens wrap at the field modulus.
  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    at_max  = (tens_q == MAX_TENS) && (units_q == MAX_UNITS);
    if (clear) begin
      tens_d  = '0;
      units_d = '0;
    end else if (inc) begin
      if (at_max) begin
        tens_d  = '0;
        units_d = '0;
      end else if (units_q == UNITS_W'(9)) begin
        tens_d  = tens_q + TENS_W'(1);
        units_d = '0;
      end else begin
        units_d = units_q + UNITS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tens_q  <= INIT_TENS;
      units_q <= INIT_UNITS;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign carry = inc && !clear && at_max;
  assign tens  = tens_q;
  assign units = units_q;

endmodule

// File: rtl/bcd_time_keeper.sv
// 24-hour BCD clock: 1 Hz tick advances seconds with carries; adjust
// pulses bump minutes/hours without carry and suppress that cycle's tick.
module bcd_time_keeper
  import bcd_time_keeper_pkg::*;
#(
  parameter int unsigned INIT_HOURS   = 0,
  parameter int unsigned INIT_MINUTES = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   adj_min,
  input  logic                   adj_hour,
  output logic [HOUR_TENS_W-1:0] hour_tens,
  output logic [UNITS_W-1:0]     hour_units,
  output logic [MIN_TENS_W-1:0]  min_tens,
  output logic [UNITS_W-1:0]     min_units,
  output logic [SEC_TENS_W-1:0]  sec_tens,
  output logic [UNITS_W-1:0]     sec_units,
  output logic                   day_wrap
);

  logic tick_ok;
  logic sec_carry, min_carry, hour_carry;
  logic min_inc, hour_inc;
  logic day_wrap_q, day_wrap_d;

  // Any adjust pulse discards the tick, so carries only come from a clean tick.
  always_comb begin
    tick_ok    = tick && !adj_min && !adj_hour;
    min_inc    = adj_min || (tick_ok && sec_carry);
    hour_inc   = adj_hour || (tick_ok && sec_carry && min_carry);
    day_wrap_d = tick_ok && sec_carry && min_carry && hour_carry;
  end

  bcd_mod_counter #(
    .MODULO (SEC_MOD),
    .TENS_W (SEC_TENS_W),
    .INIT   (8'h00)
  ) u_sec (
    .clk   (clk),
    .reset (reset),
    .inc   (tick_ok),
    .clear (adj_min),
    .tens  (sec_tens),
    .units (sec_units),
    .carry (sec_carry)
  );

  bcd_mod_counter #(
    .MODULO (MIN_MOD),
    .TENS_W (MIN_TENS_W),
    .INIT   (to_bcd(INIT_MINUTES))
  ) u_min (
    .clk   (clk),
    .reset (reset),
    .inc   (min_inc),
    .clear (1'b0),
    .tens  (min_tens),
    .units (min_units),
    .carry (min_carry)
  );

  bcd_mod_counter #(
    .MODULO (HOUR_MOD),
    .TENS_W (HOUR_TENS_W),
    .INIT   (to_bcd(INIT_HOURS))
  ) u_hour (
    .clk   (clk),
    .reset (reset),
    .inc   (hour_inc),
    .clear (1'b0),
    .tens  (hour_tens),
    .units (hour_units),
    .carry (hour_carry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      day_wrap_q <= 1'b0;
    end else begin
      day_wrap_q <= day_wrap_d;
    end
  end

  assign day_wrap = day_wrap_q;

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Scoreboard bench for bcd_time_keeper: a decimal reference model predicts
// each cycle's digits, directed scenarios add fixed-value checks.
module tb_bcd_time_keeper;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       adj_min;
  logic       adj_hour;
  logic [1:0] hour_tens;
  logic [3:0] hour_units;
  logic [2:0] min_tens;
  logic [3:0] min_units;
  logic [2:0] sec_tens;
  logic [3:0] sec_units;
  logic       day_wrap;

  int checks   = 0;
  int failures = 0;

  int   mh, mm, ms;
  logic mwrap;
  logic [20:0] exp_q[$];
  logic [20:0] dut_vec;

  bcd_time_keeper #(
    .INIT_HOURS   (12),
    .INIT_MINUTES (34)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .adj_min    (adj_min),
    .adj_hour   (adj_hour),
    .hour_tens  (hour_tens),
    .hour_units (hour_units),
    .min_tens   (min_tens),
    .min_units  (min_units),
    .sec_tens   (sec_tens),
    .sec_units  (sec_units),
    .day_wrap   (day_wrap)
  );

  always #5 clk = ~clk;

  assign dut_vec = {hour_tens, hour_units, min_tens, min_units,
                    sec_tens, sec_units, day_wrap};

  function automatic logic [20:0] pack(input int h, input int m, input int s,
                                       input logic w);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10),
            3'(s / 10), 4'(s % 10), w};
  endfunction

  function automatic logic bcd_ok();
    return (hour_tens <= 2'd2) && (hour_units <= 4'd9) &&
           (hour_tens != 2'd2 || hour_units <= 4'd3) &&
           (min_tens <= 3'd5) && (min_units <= 4'd9) &&
           (sec_tens <= 3'd5) && (sec_units <= 4'd9);
  endfunction

  task automatic check_eq(input string tag, input logic [20:0] got,
                          input logic [20:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mh = 12; mm = 34; ms = 0; mwrap = 1'b0;
  endtask

  task automatic model_step(input logic t, input logic am, input logic ah);
    mwrap = 1'b0;
    if (ah) mh = (mh + 1) % 24;
    if (am) begin
      mm = (mm + 1) % 60;
      ms = 0;
    end
    if (t && !am && !ah) begin
      ms++;
      if (ms == 60) begin
        ms = 0;
        mm++;
        if (mm == 60) begin
          mm = 0;
          mh++;
          if (mh == 24) begin
            mh = 0;
            mwrap = 1'b1;
          end
        end
      end
    end
  endtask

  // One clock cycle: drive at negedge, predict, compare #1 after the posedge.
  task automatic drive(input logic t, input logic am, input logic ah);
    logic [20:0] e;
    @(negedge clk);
    tick = t; adj_min = am; adj_hour = ah;
    model_step(t, am, ah);
    exp_q.push_back(pack(mh, mm, ms, mwrap));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", 21'(0), 21'(1));
    end else begin
      e = exp_q.pop_front();
      check_eq("cycle", dut_vec, e);
    end
    check_eq("bcd_valid", 21'(bcd_ok()), 21'(1));
  endtask

  task automatic goto_time(input int h, input int m, input int s);
    while (mh != h) drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    while (mm != m) drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < s; i++) drive(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b1; adj_min = 1'b1; adj_hour = 1'b1;
    model_reset();
    #2;
    check_eq("rst_async", dut_vec, pack(12, 34, 0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hold_pulses", dut_vec, pack(12, 34, 0, 1'b0));
    @(negedge clk);
    reset = 1'b0; tick = 1'b0; adj_min = 1'b0; adj_hour = 1'b0;
    #1;
    check_eq("rst_release", dut_vec, pack(12, 34, 0, 1'b0));
    drive(1'b1, 1'b0, 1'b0);
    check_eq("first_tick", dut_vec, pack(12, 34, 1, 1'b0));

    goto_time(23, 59, 58);
    check_eq("pre_wrap", dut_vec, pack(23, 59, 58, 1'b0));
    drive(1'b1, 1'b0, 1'b0);
    check_eq("wrap_59", dut_vec, pack(23, 59, 59, 1'b0));
    drive(1'b1, 1'b0, 1'b0);
    check_eq("day_wrap_hi", dut_vec, pack(0, 0, 0, 1'b1));
    drive(1'b0, 1'b0, 1'b0);
    check_eq("day_wrap_lo", dut_vec, pack(0, 0, 0, 1'b0));

    goto_time(10, 59, 30);
    drive(1'b0, 1'b1, 1'b0);
    check_eq("adj_min_nocarry", dut_vec, pack(10, 0, 0, 1'b0));

    goto_time(23, 15, 20);
    drive(1'b0, 1'b1, 1'b1);
    check_eq("adj_both", dut_vec, pack(0, 16, 0, 1'b0));

    goto_time(8, 9, 59);
    drive(1'b1, 1'b0, 1'b1);
    check_eq("tick_discard", dut_vec, pack(9, 9, 59, 1'b0));

    goto_time(23, 58, 50);
    for (int i = 0; i < 1000; i++) begin
      drive(1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 9) == 0));
    end

    goto_time(23, 59, 59);
    @(negedge clk);
    tick = 1'b1; reset = 1'b1;
    #1;
    check_eq("rst_midcarry", dut_vec, pack(12, 34, 0, 1'b0));
    @(posedge clk);
    #1;
    check_eq("rst_midcarry_edge", dut_vec, pack(12, 34, 0, 1'b0));
    @(negedge clk);
    reset = 1'b0; tick = 1'b0;
    model_reset();
    drive(1'b1, 1'b0, 1'b0);
    check_eq("post_midcarry", dut_vec, pack(12, 34, 1, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
